// File: rtl/btn_conditioner_if.sv
// Button/control bundle between the board buttons and the display controller.
//   nbtn_time, nbtn_dir  raw active-low push buttons (asynchronous to clk)
//   timeS, up            conditioned toggle levels for the controller
//   press_time, press_dir one-cycle pulses, one per accepted press
// slave  : the conditioner (consumes buttons, drives levels/pulses)
// master : the board/bench side
interface btn_conditioner_if;
  logic nbtn_time;
  logic nbtn_dir;
  logic timeS;
  logic up;
  logic press_time;
  logic press_dir;

  modport master (
    output nbtn_time, nbtn_dir,
    input  timeS, up, press_time, press_dir
  );

  modport slave (
    input  nbtn_time, nbtn_dir,
    output timeS, up, press_time, press_dir
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns two raw active-low buttons into toggling control
// levels (timeS, up) plus one-cycle press pulses. Each channel is a 2-FF
// synchroniser, a four-state debounce FSM with a counter, and a toggle reg.
//   clk    board clock, rising edge
//   reset  synchronous, active-high
//   btn    btn_conditioner_if.slave (buttons in, levels/pulses out)
// Parameters: fpga_f (Hz), deb_div; debounce window = max(1, fpga_f/deb_div).

// One debounce/toggle channel.
//   nbtn  raw active-low button
//   tog   toggle level, resets to TOG_INIT
//   press one-cycle pulse raised on the same edge tog flips
module btn_chan #(
  parameter int DEB_CYC  = 4,
  parameter bit TOG_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic nbtn,
  output logic tog,
  output logic press
);
  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, s2;
  logic             fire;
  // [0]: PRESS_WAIT->PRESSED taken this edge; [1]: pulse, one cycle later
  logic [1:0]       vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= RELEASED;
      cnt      <= '0;
      vld_pipe <= '0;
      tog      <= TOG_INIT;
    end else begin
      s1       <= ~nbtn;
      s2       <= s1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      vld_pipe <= {vld_pipe[0], fire};
      tog      <= tog ^ vld_pipe[0];
    end
  end

  // ">=" rather than "==" so DEB_CYC==1 (entry cnt=1, last=0) exits next cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      RELEASED: begin
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          fire      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign press = vld_pipe[1];
endmodule

module btn_conditioner #(
  parameter int fpga_f  = 50_000_000,
  parameter int deb_div = 50
) (
  input  logic               clk,
  input  logic               reset,
  btn_conditioner_if.slave   btn
);
  localparam int NUM_CH  = 2;
  localparam int DEB_CYC = (fpga_f / deb_div < 1) ? 1 : fpga_f / deb_div;

  // channel 0 = time (timeS resets to 0), channel 1 = dir (up resets to 1)
  logic [NUM_CH-1:0] nbtn;
  logic [NUM_CH-1:0] tog;
  logic [NUM_CH-1:0] press;

  assign nbtn = {btn.nbtn_dir, btn.nbtn_time};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    btn_chan #(
      .DEB_CYC  (DEB_CYC),
      .TOG_INIT (gi == 1)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .nbtn  (nbtn[gi]),
      .tog   (tog[gi]),
      .press (press[gi])
    );
  end

  assign btn.timeS      = tog[0];
  assign btn.up         = tog[1];
  assign btn.press_time = press[0];
  assign btn.press_dir  = press[1];
endmodule
